// File: rtl/fetch_buffer.sv
// Instruction fetch buffer between the fetch and decode stages.
// Small circular FIFO of {pc, insn} pairs with valid/ready on both sides and
// a synchronous flush that discards everything when the pipeline redirects.
module fetch_buffer #(
    parameter int          DEPTH = 4,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_insn,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_insn,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem_pc   [DEPTH];
    logic [31:0]   mem_insn [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic          push;
    logic          pop;

    // Handshakes are derived from occupancy only; a full buffer never passes
    // a new pair through even when decode pops in the same cycle.
    always_comb begin
        in_ready  = (count_q != CW'(DEPTH));
        out_valid = (count_q != '0);
        push      = in_valid & in_ready & ~flush;
        pop       = out_valid & out_ready & ~flush;
        count     = count_q;
    end

    // Head entry is read combinationally; empty buffer presents a NOP at pc 0.
    always_comb begin
        out_pc   = '0;
        out_insn = NOP;
        if (out_valid) begin
            out_pc   = mem_pc[rd_ptr];
            out_insn = mem_insn[rd_ptr];
        end
    end

    // Entry storage; deliberately not reset since pointers define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_pc[wr_ptr]   <= in_pc;
            mem_insn[wr_ptr] <= in_insn;
        end
    end

    // Pointers and occupancy; flush wins over push and pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_fetch_buffer;

    localparam int          DEPTH = 4;
    localparam int          CW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_pc;
    logic [31:0]   in_insn;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [31:0]   out_insn;
    logic          flush;
    logic [CW-1:0] count;

    int vectors = 0;
    int errors  = 0;

    logic [63:0] model_q [$];

    fetch_buffer #(.DEPTH(DEPTH), .NOP(NOP)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_insn   (in_insn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_insn  (out_insn),
        .flush     (flush),
        .count     (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compare every DUT output against the model's view of the queue.
    task automatic check_model(input string tag);
        int n;
        n = model_q.size();
        chk({tag, "_count"},     64'(count),     64'(n));
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(n != 0));
        chk({tag, "_in_ready"},  64'(in_ready),  64'(n != DEPTH));
        if (n != 0) begin
            chk({tag, "_out_pc"},   64'(out_pc),   64'(model_q[0][63:32]));
            chk({tag, "_out_insn"}, 64'(out_insn), 64'(model_q[0][31:0]));
        end else begin
            chk({tag, "_out_pc"},   64'(out_pc),   64'h0);
            chk({tag, "_out_insn"}, 64'(out_insn), 64'(NOP));
        end
    endtask

    // One cycle: drive inputs, check current outputs, clock, update the model.
    task automatic step(input string tag, input logic iv, input logic [31:0] pc,
                        input logic [31:0] insn, input logic ordy, input logic fl);
        bit do_push;
        bit do_pop;
        in_valid  = iv;
        in_pc     = pc;
        in_insn   = insn;
        out_ready = ordy;
        flush     = fl;
        check_model(tag);
        do_push = iv && (model_q.size() < DEPTH) && !fl;
        do_pop  = ordy && (model_q.size() > 0) && !fl;
        @(posedge clock);
        if (fl) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back({pc, insn});
        end
        #1;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        in_pc     = '0;
        in_insn   = '0;
        reset     = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        do_reset();
        check_model("reset");

        // 1: two pushes, no pops
        step("t1", 1'b1, 32'h01000000, 32'h00500093, 1'b0, 1'b0);
        step("t1", 1'b1, 32'h01000004, 32'h00100113, 1'b0, 1'b0);
        in_valid = 1'b0;
        #1;
        chk("t1_count", 64'(count), 64'd2);
        chk("t1_pc",    64'(out_pc), 64'h01000000);
        chk("t1_insn",  64'(out_insn), 64'h00500093);
        idle("t1_idle", 1);
        do_reset();

        // 2: fill, overfill attempt, then one pop
        for (int i = 0; i < DEPTH; i++)
            step("t2_fill", 1'b1, 32'h01000000 + 32'(4 * i), 32'h00000093 + 32'(i << 7), 1'b0, 1'b0);
        chk("t2_full_count", 64'(count), 64'(DEPTH));
        chk("t2_full_ready", 64'(in_ready), 64'd0);
        step("t2_over", 1'b1, 32'h01000010, 32'hdeadbeef, 1'b0, 1'b0);
        chk("t2_over_count", 64'(count), 64'(DEPTH));
        step("t2_pop", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("t2_pop_ready", 64'(in_ready), 64'd1);
        chk("t2_pop_pc",    64'(out_pc), 64'h01000004);
        do_reset();

        // 3: streaming push+pop of 10 pairs, pointers wrap twice
        for (int i = 0; i < 10; i++) begin
            step("t3_stream", 1'b1, 32'h01000000 + 32'(4 * i), 32'h10000000 + 32'(i), 1'b1, 1'b0);
            chk("t3_count", 64'(count), 64'd1);
            chk("t3_head",  64'(out_pc), 64'(32'h01000000 + 32'(4 * i)));
        end
        idle("t3_drain", 2);
        do_reset();

        // 4: flush with concurrent push and pop
        for (int i = 0; i < 3; i++)
            step("t4_fill", 1'b1, 32'h01000000 + 32'(4 * i), 32'h20000000 + 32'(i), 1'b0, 1'b0);
        step("t4_flush", 1'b1, 32'h01000040, 32'h00700193, 1'b1, 1'b1);
        chk("t4_count", 64'(count), 64'd0);
        chk("t4_valid", 64'(out_valid), 64'd0);
        chk("t4_insn",  64'(out_insn), 64'(NOP));
        idle("t4_after", 3);

        // 5: asynchronous reset with three entries buffered
        for (int i = 0; i < 3; i++)
            step("t5_fill", 1'b1, 32'h03000000 + 32'(4 * i), 32'h30000000 + 32'(i), 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("t5_async_count", 64'(count), 64'd0);
        chk("t5_async_valid", 64'(out_valid), 64'd0);
        chk("t5_async_insn",  64'(out_insn), 64'(NOP));
        model_q.delete();
        #2;
        reset = 1'b0;
        @(posedge clock);
        #1;
        step("t5_push", 1'b1, 32'h01000000, 32'h00500093, 1'b0, 1'b0);
        chk("t5_first_pc", 64'(out_pc), 64'h01000000);
        step("t5_pop", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // 6: empty with out_ready held high
        for (int i = 0; i < 5; i++)
            step("t6_empty", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 1'($urandom_range(0, 3) != 0),
                 {$urandom_range(0, 32'h003fffff), 2'b00} + 32'h01000000,
                 $urandom,
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 15) == 0));
        end
        idle("end", 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
